// File: rtl/can_clic_pipe.sv
// Pipelined priority interrupt controller: registered pending, registered winner, claim/complete.
// Define CAN_CLIC_EDGE_EN to compile in per-source rising-edge triggering.
module can_clic_pipe #(
    parameter int N_SRC  = 8,
    parameter int PRIO_W = 3,
    parameter int IDX_W  = $clog2(N_SRC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_SRC-1:0]  irq_i,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic              cfg_enable,
    input  logic [PRIO_W-1:0] cfg_prio,
    input  logic              cfg_edge,
    input  logic [PRIO_W-1:0] threshold_i,
    output logic              irq_valid_o,
    output logic [IDX_W-1:0]  irq_index_o,
    output logic [PRIO_W-1:0] irq_prio_o,
    input  logic              claim_i,
    input  logic              complete_i,
    output logic              active_o,
    output logic [PRIO_W-1:0] active_prio_o
);

    logic [N_SRC-1:0]  enable_q, enable_d;
    logic [PRIO_W-1:0] prio_q [N_SRC];
    logic [PRIO_W-1:0] prio_d [N_SRC];
    logic [N_SRC-1:0]  pending_q, pending_d;
    logic              irq_valid_q, irq_valid_d;
    logic [IDX_W-1:0]  irq_index_q, irq_index_d;
    logic [PRIO_W-1:0] irq_prio_q, irq_prio_d;
    logic              active_q, active_d;
    logic [PRIO_W-1:0] active_prio_q, active_prio_d;

    logic              cfg_ok;
    logic              claim_acc;
    logic              found;
    logic [IDX_W-1:0]  best_idx;
    logic [PRIO_W-1:0] best_prio;

`ifdef CAN_CLIC_EDGE_EN
    logic [N_SRC-1:0]  edge_q, edge_d;
    logic [N_SRC-1:0]  irq_prev_q, irq_prev_d;
`else
    logic              unused_cfg_edge;
    assign unused_cfg_edge = cfg_edge;
`endif

    assign cfg_ok    = (32'(cfg_idx) < N_SRC);
    assign claim_acc = claim_i & irq_valid_q;

    always_comb begin
        enable_d = enable_q;
        prio_d   = prio_q;
`ifdef CAN_CLIC_EDGE_EN
        edge_d   = edge_q;
`endif
        if (cfg_we && cfg_ok) begin
            enable_d[cfg_idx] = cfg_enable;
            prio_d[cfg_idx]   = cfg_prio;
`ifdef CAN_CLIC_EDGE_EN
            edge_d[cfg_idx]   = cfg_edge;
`endif
        end
    end

    // A claim only clears an edge-pending bit when no fresh edge arrives in the same cycle.
    always_comb begin
        pending_d = irq_i;
`ifdef CAN_CLIC_EDGE_EN
        irq_prev_d = irq_i;
        for (int i = 0; i < N_SRC; i++) begin
            if (edge_q[i]) begin
                pending_d[i] = (irq_i[i] & ~irq_prev_q[i]) |
                               (pending_q[i] & ~(claim_acc && (irq_index_q == IDX_W'(i))));
            end
        end
`endif
    end

    // Ascending scan with >= lets the highest index win ties.
    always_comb begin
        found     = 1'b0;
        best_idx  = '0;
        best_prio = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (pending_q[i] && enable_q[i] && (prio_q[i] > threshold_i) &&
                (prio_q[i] > active_prio_q) && (prio_q[i] >= best_prio)) begin
                found     = 1'b1;
                best_idx  = IDX_W'(i);
                best_prio = prio_q[i];
            end
        end
        irq_valid_d = found & ~claim_acc;
        irq_index_d = irq_valid_d ? best_idx : '0;
        irq_prio_d  = irq_valid_d ? best_prio : '0;
    end

    always_comb begin
        active_d      = active_q;
        active_prio_d = active_prio_q;
        if (claim_acc) begin
            active_d      = 1'b1;
            active_prio_d = irq_prio_q;
        end else if (complete_i) begin
            active_d      = 1'b0;
            active_prio_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            enable_q      <= '0;
            prio_q        <= '{default: '0};
            pending_q     <= '0;
            irq_valid_q   <= 1'b0;
            irq_index_q   <= '0;
            irq_prio_q    <= '0;
            active_q      <= 1'b0;
            active_prio_q <= '0;
`ifdef CAN_CLIC_EDGE_EN
            edge_q        <= '0;
            irq_prev_q    <= '0;
`endif
        end else begin
            enable_q      <= enable_d;
            prio_q        <= prio_d;
            pending_q     <= pending_d;
            irq_valid_q   <= irq_valid_d;
            irq_index_q   <= irq_index_d;
            irq_prio_q    <= irq_prio_d;
            active_q      <= active_d;
            active_prio_q <= active_prio_d;
`ifdef CAN_CLIC_EDGE_EN
            edge_q        <= edge_d;
            irq_prev_q    <= irq_prev_d;
`endif
        end
    end

    assign irq_valid_o   = irq_valid_q;
    assign irq_index_o   = irq_index_q;
    assign irq_prio_o    = irq_prio_q;
    assign active_o      = active_q;
    assign active_prio_o = active_prio_q;

endmodule

// File: tb/tb_can_clic_pipe.sv
// Scoreboard bench for can_clic_pipe (N_SRC=4): expectations are queued with a target cycle
// and checked against the outputs on the falling edge of that cycle.
module tb_can_clic_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq_i;
    logic       cfg_we;
    logic [1:0] cfg_idx;
    logic       cfg_enable;
    logic [2:0] cfg_prio;
    logic       cfg_edge;
    logic [2:0] threshold_i;
    logic       irq_valid_o;
    logic [1:0] irq_index_o;
    logic [2:0] irq_prio_o;
    logic       claim_i;
    logic       complete_i;
    logic       active_o;
    logic [2:0] active_prio_o;

    can_clic_pipe #(.N_SRC(4), .PRIO_W(3)) dut (
        .clk(clk), .reset(reset), .irq_i(irq_i),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_enable(cfg_enable),
        .cfg_prio(cfg_prio), .cfg_edge(cfg_edge), .threshold_i(threshold_i),
        .irq_valid_o(irq_valid_o), .irq_index_o(irq_index_o), .irq_prio_o(irq_prio_o),
        .claim_i(claim_i), .complete_i(complete_i),
        .active_o(active_o), .active_prio_o(active_prio_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        string      tag;
        logic       v;
        logic [1:0] idx;
        logic [2:0] pr;
        logic       act;
        logic [2:0] ap;
    } exp_t;

    exp_t sbq[$];
    int   cycle = 0;
    int   testsRun = 0;
    int   testsFailed = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, want %0d (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sbq.size() > 0 && sbq[0].cyc <= cycle) begin
            e = sbq.pop_front();
            checkOutput({e.tag, ".valid"}, 32'(irq_valid_o), 32'(e.v));
            checkOutput({e.tag, ".index"}, 32'(irq_index_o), 32'(e.idx));
            checkOutput({e.tag, ".prio"}, 32'(irq_prio_o), 32'(e.pr));
            checkOutput({e.tag, ".active"}, 32'(active_o), 32'(e.act));
            checkOutput({e.tag, ".active_prio"}, 32'(active_prio_o), 32'(e.ap));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expectOut(input int d, input string tag, input logic v, input logic [1:0] idx,
                             input logic [2:0] pr, input logic act, input logic [2:0] ap);
        exp_t e;
        e.cyc = cycle + d;
        e.tag = tag;
        e.v   = v;
        e.idx = idx;
        e.pr  = pr;
        e.act = act;
        e.ap  = ap;
        sbq.push_back(e);
    endtask

    task automatic applyStimulus(input logic [3:0] irq, input logic [2:0] thr,
                                 input logic clm, input logic cmp);
        irq_i       = irq;
        threshold_i = thr;
        claim_i     = clm;
        complete_i  = cmp;
    endtask

    task automatic cfgWrite(input logic [1:0] idx, input logic en, input logic [2:0] pr, input logic edg);
        cfg_we     = 1'b1;
        cfg_idx    = idx;
        cfg_enable = en;
        cfg_prio   = pr;
        cfg_edge   = edg;
        step(1);
        cfg_we     = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        cfg_we = 1'b0; cfg_idx = '0; cfg_enable = 1'b0; cfg_prio = '0; cfg_edge = 1'b0;
        applyStimulus(4'b0000, 3'd0, 1'b0, 1'b0);
        step(1);
        expectOut(1, "reset", 0, 0, 0, 0, 0);
        step(1);
        reset = 1'b0;

        cfgWrite(2'd0, 1'b1, 3'd1, 1'b0);
        cfgWrite(2'd1, 1'b1, 3'd2, 1'b0);
        cfgWrite(2'd2, 1'b1, 3'd3, 1'b0);
        cfgWrite(2'd3, 1'b1, 3'd3, 1'b0);
        applyStimulus(4'b1111, 3'd0, 1'b0, 1'b0);
        expectOut(1, "pend_stage", 0, 0, 0, 0, 0);
        expectOut(2, "tie_break", 1, 3, 3, 0, 0);
        step(2);

        applyStimulus(4'b0111, 3'd0, 1'b1, 1'b0);
        expectOut(1, "claim_mask", 0, 0, 0, 1, 3);
        step(1);
        applyStimulus(4'b0111, 3'd0, 1'b0, 1'b0);
        expectOut(1, "equal_prio_held", 0, 0, 0, 1, 3);
        step(1);
        applyStimulus(4'b0111, 3'd0, 1'b0, 1'b1);
        expectOut(1, "complete", 0, 0, 0, 0, 0);
        expectOut(2, "after_complete", 1, 2, 3, 0, 0);
        step(1);
        applyStimulus(4'b0111, 3'd0, 1'b0, 1'b0);
        step(1);

        cfgWrite(2'd0, 1'b1, 3'd0, 1'b0);
        cfgWrite(2'd1, 1'b1, 3'd0, 1'b0);
        cfgWrite(2'd3, 1'b1, 3'd0, 1'b0);
        applyStimulus(4'b1111, 3'd3, 1'b0, 1'b0);
        expectOut(1, "thr_block", 0, 0, 0, 0, 0);
        step(1);
        applyStimulus(4'b1111, 3'd2, 1'b0, 1'b0);
        expectOut(1, "thr_lower", 1, 2, 3, 0, 0);
        step(1);
        applyStimulus(4'b1011, 3'd0, 1'b0, 1'b0);
        expectOut(1, "src2_drop_lag", 1, 2, 3, 0, 0);
        expectOut(2, "prio_zero", 0, 0, 0, 0, 0);
        step(2);

        applyStimulus(4'b0000, 3'd0, 1'b0, 1'b0);
        cfgWrite(2'd0, 1'b1, 3'd5, 1'b0);
        cfgWrite(2'd1, 1'b1, 3'd2, 1'b0);
        applyStimulus(4'b0010, 3'd0, 1'b0, 1'b0);
        expectOut(2, "pre_base", 1, 1, 2, 0, 0);
        step(2);
        applyStimulus(4'b0010, 3'd0, 1'b1, 1'b0);
        expectOut(1, "pre_claim", 0, 0, 0, 1, 2);
        step(1);
        applyStimulus(4'b0011, 3'd0, 1'b0, 1'b0);
        expectOut(1, "pre_wait", 0, 0, 0, 1, 2);
        expectOut(2, "preempt_offer", 1, 0, 5, 1, 2);
        step(2);
        applyStimulus(4'b0011, 3'd0, 1'b1, 1'b1);
        expectOut(1, "claim_beats_complete", 0, 0, 0, 1, 5);
        step(1);
        applyStimulus(4'b0011, 3'd0, 1'b0, 1'b1);
        expectOut(1, "complete2", 0, 0, 0, 0, 0);
        expectOut(2, "reoffer", 1, 0, 5, 0, 0);
        step(1);
        applyStimulus(4'b0011, 3'd0, 1'b0, 1'b0);
        step(1);

        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_enable = 1'b0; cfg_prio = 3'd5; cfg_edge = 1'b0;
        expectOut(1, "dis_lag", 1, 0, 5, 0, 0);
        expectOut(2, "dis_drop", 1, 1, 2, 0, 0);
        step(1);
        cfg_we = 1'b0;
        step(1);

`ifdef CAN_CLIC_EDGE_EN
        applyStimulus(4'b0000, 3'd0, 1'b0, 1'b0);
        step(2);
        cfgWrite(2'd0, 1'b1, 3'd5, 1'b1);
        applyStimulus(4'b0001, 3'd0, 1'b0, 1'b0);
        expectOut(2, "edge_offer", 1, 0, 5, 0, 0);
        step(1);
        applyStimulus(4'b0000, 3'd0, 1'b0, 1'b0);
        step(1);
        expectOut(1, "edge_held", 1, 0, 5, 0, 0);
        step(1);
        applyStimulus(4'b0001, 3'd0, 1'b1, 1'b0);
        expectOut(1, "edge_claim", 0, 0, 0, 1, 5);
        step(1);
        applyStimulus(4'b0000, 3'd0, 1'b0, 1'b1);
        expectOut(1, "edge_cmp", 0, 0, 0, 0, 0);
        expectOut(2, "edge_kept", 1, 0, 5, 0, 0);
        step(1);
        applyStimulus(4'b0000, 3'd0, 1'b0, 1'b0);
        step(1);
        applyStimulus(4'b0000, 3'd0, 1'b1, 1'b0);
        expectOut(1, "edge_claim2", 0, 0, 0, 1, 5);
        step(1);
        applyStimulus(4'b0000, 3'd0, 1'b0, 1'b1);
        expectOut(2, "edge_cleared", 0, 0, 0, 0, 0);
        step(1);
        applyStimulus(4'b0000, 3'd0, 1'b0, 1'b0);
        step(1);
        cfgWrite(2'd0, 1'b0, 3'd0, 1'b0);
`endif

        applyStimulus(4'b0010, 3'd0, 1'b0, 1'b0);
        expectOut(2, "rst_base", 1, 1, 2, 0, 0);
        step(2);
        applyStimulus(4'b0010, 3'd0, 1'b1, 1'b0);
        expectOut(1, "rst_claim", 0, 0, 0, 1, 2);
        step(1);
        applyStimulus(4'b0110, 3'd0, 1'b0, 1'b0);
        expectOut(2, "rst_preoffer", 1, 2, 3, 1, 2);
        step(2);
        reset = 1'b1;
        expectOut(1, "mid_reset", 0, 0, 0, 0, 0);
        step(1);
        reset = 1'b0;
        cfg_we = 1'b1; cfg_idx = 2'd2; cfg_enable = 1'b1; cfg_prio = 3'd3; cfg_edge = 1'b0;
        expectOut(1, "post_rst1", 0, 0, 0, 0, 0);
        expectOut(2, "post_rst2", 1, 2, 3, 0, 0);
        step(1);
        cfg_we = 1'b0;
        step(3);

        checkOutput("sb_drain", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
